game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
Top-level game flow controller: the producer of the menuScreen / playerWon / playerLost controls consumed by the obstacle position / game-time counter, and the consumer of that counter's game_time.
- Tracks menu, play, hit-pause, level-won and game-over phases.
- Manages lives and level number.
- Times the result screens in video frames.
- Sits between the button/collision logic and the counter/renderer.

Parameters:
LEVEL_LEN, 1000, game_time value that completes level 0 (11-bit).
LEVEL_STEP, 250, extra game_time required per subsequent level; LEVEL_LEN+(LEVELS-1)*LEVEL_STEP must be ≤ 2047.
LIVES, 3, lives at game start (1..3).
LEVELS, 3, number of levels (1..4).
HOLD_FRAMES, 60, frame_tick pulses a result screen is held (≥1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start_btn  in  1  synchronised, debounced start button level
collision  in  1  player/obstacle overlap level, valid only in PLAY
game_time  in  11  elapsed level time from the counter (0 whenever menuScreen/playerWon/playerLost high)
menuScreen  out  1  menu displayed; holds counter in reset
playerWon  out  1  level-won screen; holds counter in reset
playerLost  out  1  life lost or game over; holds counter in reset
game_over  out  1  high only in LOST
game_complete  out  1  high in WON after final level
lives_left  out  2  remaining lives
level_num  out  2  current level, 0-based
state_code  out  3  MENU=0, PLAY=1, HIT=2, WON=3, LOST=4 (for display)

Behaviour:
- Reset values:
  - state MENU; menuScreen=1; all other flags 0.
  - lives_left=LIVES; level_num=0; hold counter 0; start_prev=0.
  - A button held through reset release therefore yields one start edge.
- Start edge: start_edge = start_btn & ~start_prev; start_prev is registered every cycle.
- Outputs are registered Moore outputs decoded from the state: they change the cycle after the transition condition is sampled.
- Level threshold: thr = LEVEL_LEN + level_num*LEVEL_STEP, computed in 11 bits.
- MENU:
  - on start_edge → PLAY; lives_left=LIVES; level_num=0.
- PLAY:
  - collision=1 and lives_left==1 → LOST; lives_left=0.
  - collision=1 and lives_left>1 → HIT; lives_left-1.
  - else game_time ≥ thr → WON.
  - collision has priority over the win condition in the same cycle.
  - start_edge is ignored.
- HIT:
  - playerLost=1.
  - Hold counter loads 0 on entry and increments on each frame_tick.
  - When the counter reaches HOLD_FRAMES-1 with frame_tick → PLAY at the same level_num.
  - collision is ignored.
- WON:
  - playerWon=1; hold counter as in HIT.
  - On hold expiry with level_num<LEVELS-1 → level_num+1 and PLAY.
  - If level_num==LEVELS-1: hold expiry sets an internal done flag and game_complete=1. The state stays WON until the first start_edge after expiry, then → MENU.
- LOST:
  - playerLost=1; game_over=1.
  - After hold expiry, the first start_edge → MENU.
- Start edges during any hold period are discarded, not queued.
- The hold counter is ⌈log2(HOLD_FRAMES)⌉ bits (minimum 1) and is cleared on every state entry.
- frame_tick coincident with the state-entry cycle does not count.
- Reset asserted mid-operation returns to MENU immediately (asynchronous) with all reset values.
- Lives never underflow: LOST is entered at lives_left 1→0, never decremented from 0.
- Illegal state encodings → MENU on the next clock.

Test Plan:
1. Reset release with start_btn=0 → menuScreen=1, lives_left=3, level_num=0, state_code=0. Then a start_btn pulse → state_code=1 and menuScreen=0 one cycle after the edge.
2. PLAY level 0, sweep game_time 998→999→1000 → playerWon=1 on the cycle after game_time=1000. After 60 frame_ticks → PLAY with level_num=1; threshold now 1250 (game_time=1249 no win, 1250 win).
3. PLAY with lives 3, collision pulse → HIT, playerLost=1, lives_left=2, game_over=0. 60 frame_ticks → PLAY. Collision and game_time=1000 on the same cycle → HIT, not WON.
4. Three collisions separated by holds → third goes to LOST with lives_left=0 and game_over=1. A start edge at frame 30 is ignored; a start edge after frame 60 → MENU, then start → lives_left=3.
5. Win levels 0, 1, 2 (thresholds 1000/1250/1500) → after the final hold game_complete=1 and the state stays WON. A start edge → MENU with level_num=0.
6. Assert reset asynchronously mid-HIT (hold counter 25) → outputs at reset values without waiting for clk. Hold start_btn high across reset release → exactly one start edge → PLAY.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Game flow controller: menu/play/hit/won/lost phases, lives, level, result-screen hold.
// In: clk, reset, frame_tick, start_btn, collision, game_time[10:0]. Out: screen flags, lives_left, level_num, state_code.
module game_state_ctrl #(
  parameter int LEVEL_LEN   = 1000,
  parameter int LEVEL_STEP  = 250,
  parameter int LIVES       = 3,
  parameter int LEVELS      = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        collision,
  input  logic [10:0] game_time,
  output logic        menuScreen,
  output logic        playerWon,
  output logic        playerLost,
  output logic        game_over,
  output logic        game_complete,
  output logic [1:0]  lives_left,
  output logic [1:0]  level_num,
  output logic [2:0]  state_code
);

  localparam int HW =
    (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_FRAMES - 1);
  localparam logic [1:0] LAST_LVL = 2'(LEVELS - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_MENU = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WON  = 3'd3,
    S_LOST = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      lives_q, lives_d;
  logic [1:0]      level_q, level_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            done_q, done_d;
  logic            start_prev_q;

  logic            start_edge;
  logic            holding;
  logic            expire;
  logic [10:0]     thr;

  assign start_edge = start_btn & ~start_prev_q;
  assign thr = 11'(LEVEL_LEN)
             + 11'(level_q) * 11'(LEVEL_STEP);
  assign holding = (state_q == S_HIT)
                 | (state_q == S_WON)
                 | (state_q == S_LOST);
  // done_q freezes the counter once a terminal hold has run out
  assign expire = holding & frame_tick & ~done_q
                & (hold_q == HOLD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_MENU;
      lives_q      <= LIVES_INIT;
      level_q      <= 2'd0;
      hold_q       <= '0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      start_prev_q <= start_btn;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    done_d  = done_q;
    hold_d  = hold_q;
    case (state_q)
      S_MENU: begin
        if (start_edge) begin
          state_d = S_PLAY;
          lives_d = LIVES_INIT;
          level_d = 2'd0;
        end
      end
      S_PLAY: begin
        if (collision) begin
          if (lives_q <= 2'd1) begin
            state_d = S_LOST;
            lives_d = 2'd0;
          end else begin
            state_d = S_HIT;
            lives_d = lives_q - 2'd1;
          end
        end else if (game_time >= thr) begin
          state_d = S_WON;
        end
      end
      S_HIT: begin
        if (expire) state_d = S_PLAY;
      end
      S_WON: begin
        if (done_q) begin
          if (start_edge) begin
            state_d = S_MENU;
            level_d = 2'd0;
          end
        end else if (expire) begin
          if (level_q == LAST_LVL) begin
            done_d = 1'b1;
          end else begin
            level_d = level_q + 2'd1;
            state_d = S_PLAY;
          end
        end
      end
      S_LOST: begin
        if (done_q) begin
          if (start_edge) begin
            state_d = S_MENU;
            level_d = 2'd0;
          end
        end else if (expire) begin
          done_d = 1'b1;
        end
      end
      default: state_d = S_MENU;
    endcase
    // every state entry restarts the hold; the entry-cycle tick is lost
    if (state_d != state_q) begin
      hold_d = '0;
      done_d = 1'b0;
    end else if (holding & frame_tick & ~done_q) begin
      hold_d = hold_q + 1'b1;
    end
  end

  assign menuScreen    = (state_q == S_MENU);
  assign playerWon     = (state_q == S_WON);
  assign playerLost    = (state_q == S_HIT)
                       | (state_q == S_LOST);
  assign game_over     = (state_q == S_LOST);
  assign game_complete = (state_q == S_WON) & done_q;
  assign lives_left    = lives_q;
  assign level_num     = level_q;
  assign state_code    = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios with literal checks,
// then random stimulus, all compared every cycle against a phase model.
module tb_game_state_ctrl;

  localparam int LEVEL_LEN   = 1000;
  localparam int LEVEL_STEP  = 250;
  localparam int LIVES       = 3;
  localparam int LEVELS      = 3;
  localparam int HOLD_FRAMES = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        start_btn;
  logic        collision;
  logic [10:0] game_time;
  logic        menuScreen, playerWon, playerLost;
  logic        game_over, game_complete;
  logic [1:0]  lives_left, level_num;
  logic [2:0]  state_code;

  int total = 0;
  int bad   = 0;

  int m_st, m_lives, m_lvl, m_ticks;
  bit m_done, m_prev;

  always #5 clk = ~clk;

  game_state_ctrl #(
    .LEVEL_LEN(LEVEL_LEN),
    .LEVEL_STEP(LEVEL_STEP),
    .LIVES(LIVES),
    .LEVELS(LEVELS),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .start_btn(start_btn),
    .collision(collision),
    .game_time(game_time),
    .menuScreen(menuScreen),
    .playerWon(playerWon),
    .playerLost(playerLost),
    .game_over(game_over),
    .game_complete(game_complete),
    .lives_left(lives_left),
    .level_num(level_num),
    .state_code(state_code)
  );

  task automatic check(input string nm,
                       input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // phase model: 0 menu, 1 play, 2 hit, 3 won, 4 lost
  always @(posedge clk or posedge reset) begin : model
    automatic int st, lv, lc, tk;
    automatic bit dn, se;
    if (reset) begin
      m_st    <= 0;
      m_lives <= LIVES;
      m_lvl   <= 0;
      m_ticks <= 0;
      m_done  <= 0;
      m_prev  <= 0;
    end else begin
      st = m_st; lv = m_lives; lc = m_lvl;
      tk = m_ticks; dn = m_done;
      se = start_btn && !m_prev;
      case (m_st)
        0: if (se) begin
          st = 1; lv = LIVES; lc = 0;
        end
        1: if (collision) begin
          lv = lv - 1;
          st = (lv == 0) ? 4 : 2;
        end else if (int'(game_time) >=
                     LEVEL_LEN + m_lvl * LEVEL_STEP) begin
          st = 3;
        end
        default: begin
          if (dn) begin
            if (se && m_st != 2) begin
              st = 0; lc = 0;
            end
          end else if (frame_tick) begin
            tk++;
            if (tk == HOLD_FRAMES) begin
              if (m_st == 2) st = 1;
              else if (m_st == 3 && lc < LEVELS - 1) begin
                lc++; st = 1;
              end else dn = 1;
            end
          end
        end
      endcase
      if (st != m_st) begin
        tk = 0; dn = 0;
      end
      m_st    <= st;
      m_lives <= lv;
      m_lvl   <= lc;
      m_ticks <= tk;
      m_done  <= dn;
      m_prev  <= start_btn;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("menu", menuScreen, m_st == 0);
      check("won", playerWon, m_st == 3);
      check("lost", playerLost, m_st == 2 || m_st == 4);
      check("over", game_over, m_st == 4);
      check("complete", game_complete,
            m_st == 3 && m_done);
      check("lives", lives_left, m_lives);
      check("level", level_num, m_lvl);
      check("code", state_code, m_st);
    end
  end

  task automatic drv(input logic ft, input logic sb,
                     input logic col, input logic [10:0] gt);
    frame_tick = ft;
    start_btn  = sb;
    collision  = col;
    game_time  = gt;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drv(1, 0, 0, 0);
      drv(0, 0, 0, 0);
    end
  endtask

  logic rsb;

  initial begin
    reset = 1; frame_tick = 0; start_btn = 0;
    collision = 0; game_time = 0;
    repeat (3) @(negedge clk);
    check("L_rst_menu", menuScreen, 1);
    check("L_rst_lives", lives_left, 3);
    check("L_rst_level", level_num, 0);
    check("L_rst_code", state_code, 0);
    check("L_rst_cmp", game_complete, 0);
    reset = 0;
    drv(0, 0, 0, 0);
    check("L_idle_code", state_code, 0);
    drv(0, 1, 0, 0);
    check("L_start_code", state_code, 1);
    check("L_start_menu", menuScreen, 0);
    drv(0, 0, 0, 998);
    check("L_998", state_code, 1);
    drv(0, 0, 0, 999);
    check("L_999", state_code, 1);
    drv(0, 0, 0, 1000);
    check("L_1000_code", state_code, 3);
    check("L_1000_won", playerWon, 1);
    drv(0, 0, 0, 0);
    ticks(59);
    check("L_hold59", state_code, 3);
    ticks(1);
    check("L_hold60", state_code, 1);
    check("L_lvl1", level_num, 1);
    drv(0, 0, 0, 1249);
    check("L_1249", state_code, 1);
    drv(0, 0, 0, 1250);
    check("L_1250", state_code, 3);
    ticks(60);
    check("L_lvl2", level_num, 2);
    drv(0, 0, 1, 0);
    check("L_hit_code", state_code, 2);
    check("L_hit_lost", playerLost, 1);
    check("L_hit_lives", lives_left, 2);
    check("L_hit_over", game_over, 0);
    drv(0, 0, 0, 0);
    ticks(60);
    check("L_hit_back", state_code, 1);
    drv(0, 0, 1, 1500);
    check("L_prio", state_code, 2);
    check("L_prio_lives", lives_left, 1);
    ticks(60);
    drv(0, 0, 1, 0);
    check("L_lost_code", state_code, 4);
    check("L_lost_lives", lives_left, 0);
    check("L_lost_over", game_over, 1);
    drv(0, 0, 0, 0);
    ticks(30);
    drv(0, 1, 0, 0);
    check("L_lost_ign", state_code, 4);
    drv(0, 0, 0, 0);
    ticks(30);
    check("L_lost_wait", state_code, 4);
    drv(0, 1, 0, 0);
    check("L_lost_menu", state_code, 0);
    check("L_lost_lvl0", level_num, 0);
    drv(0, 0, 0, 0);
    drv(0, 1, 0, 0);
    check("L_restart", state_code, 1);
    check("L_relives", lives_left, 3);
    drv(0, 0, 0, 1000);
    ticks(60);
    drv(0, 0, 0, 1250);
    ticks(60);
    drv(0, 0, 0, 1500);
    check("L_w2", state_code, 3);
    ticks(60);
    check("L_cmp", game_complete, 1);
    ticks(5);
    check("L_cmp_stay", state_code, 3);
    drv(0, 1, 0, 0);
    check("L_cmp_menu", state_code, 0);
    check("L_cmp_lvl", level_num, 0);
    drv(0, 0, 0, 0);
    drv(0, 1, 0, 0);
    drv(0, 0, 1, 0);
    check("L_hit2", state_code, 2);
    drv(0, 0, 0, 0);
    ticks(25);
    #2 reset = 1; start_btn = 1;
    #1;
    check("L_arst_code", state_code, 0);
    check("L_arst_menu", menuScreen, 1);
    check("L_arst_lives", lives_left, 3);
    check("L_arst_lost", playerLost, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    drv(0, 1, 0, 0);
    check("L_hold_btn", state_code, 1);
    drv(0, 1, 0, 0);
    check("L_one_edge", state_code, 1);
    rsb = 1;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 2999) == 0) begin
        #1 reset = 1;
        #2 reset = 0;
        @(negedge clk);
      end else begin
        if ($urandom_range(0, 7) == 0) rsb = ~rsb;
        drv($urandom_range(0, 1) == 0, rsb,
            $urandom_range(0, 29) == 0,
            11'($urandom_range(0, 1600)));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
